// File: rtl/tt_memop_tracker_pkg.sv
// ---------------------------------------------------------------------------
// tt_memop_pkg : shared slot types and helpers for the OVI memop tracker
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tt_memop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PREPARE = 2'b01,
    BUSY    = 2'b10,
    COMMIT  = 2'b11
  } memop_state_t;

  typedef struct packed {
    memop_state_t state;
    logic         is_store;
    logic         sync_sent;
  } memop_slot_t;

  localparam memop_slot_t SLOT_RESET = '{state: IDLE, is_store: 1'b0, sync_sent: 1'b0};

  // Slot ids are at least one bit wide so a single-slot tracker still has a port.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_memop_tracker_if.sv
// ---------------------------------------------------------------------------
// tt_memop_tracker_if : ID/EX handshake and OVI memop sync bundle
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tt_memop_tracker_if
#(
  parameter int NUM_SLOTS = 2,
  parameter int WDOG_W    = 12
);
  import tt_memop_pkg::*;

  localparam int SLOT_W = slot_width(NUM_SLOTS);

  logic              i_load;
  logic              i_store;
  logic              i_id_ex_rts;
  logic              i_ex_rtr;
  logic              i_last_uop;
  logic              i_lq_empty;
  logic              i_mem_req;
  logic              i_memop_sync_end;
  logic [SLOT_W-1:0] i_sync_end_id;
  logic [WDOG_W-1:0] i_wdog_limit;
  logic              o_memop_sync_start;
  logic [SLOT_W-1:0] o_sync_start_id;
  logic              o_completed_valid;
  logic [SLOT_W-1:0] o_completed_id;
  logic              o_ovi_stall;
  logic              o_wdog_expired;
  logic              o_err;

  modport master (
    output i_load, i_store, i_id_ex_rts, i_ex_rtr, i_last_uop, i_lq_empty,
           i_mem_req, i_memop_sync_end, i_sync_end_id, i_wdog_limit,
    input  o_memop_sync_start, o_sync_start_id, o_completed_valid,
           o_completed_id, o_ovi_stall, o_wdog_expired, o_err
  );

  modport slave (
    input  i_load, i_store, i_id_ex_rts, i_ex_rtr, i_last_uop, i_lq_empty,
           i_mem_req, i_memop_sync_end, i_sync_end_id, i_wdog_limit,
    output o_memop_sync_start, o_sync_start_id, o_completed_valid,
           o_completed_id, o_ovi_stall, o_wdog_expired, o_err
  );

endinterface

`default_nettype wire

// File: rtl/tt_memop_tracker_slot.sv
// ---------------------------------------------------------------------------
// tt_memop_slot : next-state logic for one tracked memop slot
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_memop_slot
  import tt_memop_pkg::*;
(
  input  memop_slot_t i_slot,
  input  logic        i_alloc,
  input  logic        i_alloc_store,
  input  logic        i_alloc_last,
  input  logic        i_promote,
  input  logic        i_start,
  input  logic        i_end,
  input  logic        i_retire,
  output memop_slot_t o_slot
);

  // The top only raises an event when the slot is in the matching state,
  // so at most one of these applies to a given slot in any cycle.
  always_comb begin
    o_slot = i_slot;
    if (i_alloc) begin
      o_slot.state     = i_alloc_last ? BUSY : PREPARE;
      o_slot.is_store  = i_alloc_store;
      o_slot.sync_sent = 1'b0;
    end
    if (i_promote) o_slot.state = BUSY;
    if (i_start)   o_slot.sync_sent = 1'b1;
    if (i_end)     o_slot.state = COMMIT;
    if (i_retire)  o_slot = SLOT_RESET;
  end

endmodule

`default_nettype wire

// File: rtl/tt_memop_tracker.sv
// ---------------------------------------------------------------------------
// tt_memop_tracker : multi-slot in-order vector memop tracker for OVI sync
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_memop_tracker
  import tt_memop_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int WDOG_W    = 12
)
(
  input  logic              i_clk,
  input  logic              i_reset,
  tt_memop_tracker_if.slave bus
);

  localparam int SLOT_W = slot_width(NUM_SLOTS);
  typedef logic [SLOT_W-1:0] slot_id_t;

  memop_slot_t slot_q [NUM_SLOTS];
  memop_slot_t slot_d [NUM_SLOTS];

  slot_id_t          tail_q, tail_d;
  slot_id_t          head_q, head_d;
  slot_id_t          sync_q, sync_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_exp_q, wdog_exp_d;
  logic              err_q, err_d;

  logic [NUM_SLOTS-1:0] alloc_vec, promote_vec, start_vec, end_vec, retire_vec;
  logic                 accept, prep_exists, all_busy;
  logic                 fire_start, end_ok, fire_retire, head_watched;
  slot_id_t             prep_idx;

  function automatic slot_id_t ptr_inc(input slot_id_t p);
    return (p == slot_id_t'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    prep_exists = 1'b0;
    prep_idx    = '0;
    all_busy    = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q[i].state == PREPARE) begin
        prep_exists = 1'b1;
        prep_idx    = slot_id_t'(i);
      end
      if (slot_q[i].state == IDLE) all_busy = 1'b0;
    end
  end

  always_comb begin
    alloc_vec   = '0;
    promote_vec = '0;
    start_vec   = '0;
    end_vec     = '0;
    retire_vec  = '0;
    tail_d      = tail_q;
    head_d      = head_q;
    sync_d      = sync_q;
    err_d       = err_q;

    accept = bus.i_id_ex_rts && bus.i_ex_rtr && (bus.i_load || bus.i_store);
    if (accept) begin
      if (prep_exists) begin
        if (bus.i_last_uop) promote_vec[prep_idx] = 1'b1;
      end else if (slot_q[tail_q].state == IDLE) begin
        alloc_vec[tail_q] = 1'b1;
        tail_d            = ptr_inc(tail_q);
      end else begin
        err_d = 1'b1;
      end
    end

    // Stores need no load-request quiet time, but still get exactly one start.
    fire_start = (slot_q[sync_q].state == BUSY) && !slot_q[sync_q].sync_sent &&
                 (slot_q[sync_q].is_store || !bus.i_mem_req);
    if (fire_start) begin
      start_vec[sync_q] = 1'b1;
      sync_d            = ptr_inc(sync_q);
    end

    end_ok = (slot_q[bus.i_sync_end_id].state == BUSY) && slot_q[bus.i_sync_end_id].sync_sent;
    if (bus.i_memop_sync_end) begin
      if (end_ok) end_vec[bus.i_sync_end_id] = 1'b1;
      else        err_d = 1'b1;
    end

    fire_retire = (slot_q[head_q].state == COMMIT) && bus.i_lq_empty;
    if (fire_retire) begin
      retire_vec[head_q] = 1'b1;
      head_d             = ptr_inc(head_q);
    end

    // A retiring head is in COMMIT, so a head change always clears the count.
    head_watched = (slot_q[head_q].state == BUSY) && slot_q[head_q].sync_sent;
    if (head_watched) wdog_d = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
    else              wdog_d = '0;
    wdog_exp_d = wdog_exp_q |
                 (head_watched && (bus.i_wdog_limit != '0) && (wdog_d == bus.i_wdog_limit));
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    tt_memop_slot u_slot (
      .i_slot        (slot_q[g]),
      .i_alloc       (alloc_vec[g]),
      .i_alloc_store (bus.i_store),
      .i_alloc_last  (bus.i_last_uop),
      .i_promote     (promote_vec[g]),
      .i_start       (start_vec[g]),
      .i_end         (end_vec[g]),
      .i_retire      (retire_vec[g]),
      .o_slot        (slot_d[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= SLOT_RESET;
      tail_q     <= '0;
      head_q     <= '0;
      sync_q     <= '0;
      wdog_q     <= '0;
      wdog_exp_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
      tail_q     <= tail_d;
      head_q     <= head_d;
      sync_q     <= sync_d;
      wdog_q     <= wdog_d;
      wdog_exp_q <= wdog_exp_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_memop_sync_start = fire_start;
  assign bus.o_sync_start_id    = sync_q;
  assign bus.o_completed_valid  = fire_retire;
  assign bus.o_completed_id     = head_q;
  assign bus.o_ovi_stall        = all_busy && !prep_exists;
  assign bus.o_wdog_expired     = wdog_exp_q;
  assign bus.o_err              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_memop_tracker.sv
// ---------------------------------------------------------------------------
// tb_tt_memop_tracker : directed bench for a 2-slot tracker plus a 1-slot shadow
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tt_memop_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tt_memop_tracker_if #(.NUM_SLOTS(2), .WDOG_W(12)) bus ();
  tt_memop_tracker_if #(.NUM_SLOTS(1), .WDOG_W(12)) bus1 ();

  // The single-slot instance sees the same stimulus as the main one.
  assign bus1.i_load           = bus.i_load;
  assign bus1.i_store          = bus.i_store;
  assign bus1.i_id_ex_rts      = bus.i_id_ex_rts;
  assign bus1.i_ex_rtr         = bus.i_ex_rtr;
  assign bus1.i_last_uop       = bus.i_last_uop;
  assign bus1.i_lq_empty       = bus.i_lq_empty;
  assign bus1.i_mem_req        = bus.i_mem_req;
  assign bus1.i_memop_sync_end = bus.i_memop_sync_end;
  assign bus1.i_sync_end_id    = bus.i_sync_end_id;
  assign bus1.i_wdog_limit     = bus.i_wdog_limit;

  tt_memop_tracker #(.NUM_SLOTS(2), .WDOG_W(12)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  tt_memop_tracker #(.NUM_SLOTS(1), .WDOG_W(12)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs2();
    return {25'd0, bus.o_memop_sync_start, bus.o_sync_start_id, bus.o_completed_valid,
            bus.o_completed_id, bus.o_ovi_stall, bus.o_wdog_expired, bus.o_err};
  endfunction

  function automatic logic [31:0] outs1();
    return {25'd0, bus1.o_memop_sync_start, bus1.o_sync_start_id, bus1.o_completed_valid,
            bus1.o_completed_id, bus1.o_ovi_stall, bus1.o_wdog_expired, bus1.o_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    bus.i_load           = 1'b0;
    bus.i_store          = 1'b0;
    bus.i_id_ex_rts      = 1'b0;
    bus.i_ex_rtr         = 1'b0;
    bus.i_last_uop       = 1'b0;
    bus.i_lq_empty       = 1'b1;
    bus.i_mem_req        = 1'b0;
    bus.i_memop_sync_end = 1'b0;
    bus.i_sync_end_id    = 1'b0;
  endtask

  task automatic uop(input logic st, input logic last);
    bus.i_load      = !st;
    bus.i_store     = st;
    bus.i_id_ex_rts = 1'b1;
    bus.i_ex_rtr    = 1'b1;
    bus.i_last_uop  = last;
  endtask

  task automatic no_uop();
    bus.i_load      = 1'b0;
    bus.i_store     = 1'b0;
    bus.i_id_ex_rts = 1'b0;
    bus.i_ex_rtr    = 1'b0;
    bus.i_last_uop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.i_wdog_limit = 12'd0;
    do_reset();
    settle();
    chk("reset_outputs", outs2(), 32'd0);
    chk("reset_outputs_1slot", outs1(), 32'd0);

    // Single-uop load with no memory request outstanding.
    uop(1'b0, 1'b1); settle();
    chk("t1_accept_stall", bus.o_ovi_stall, 1'b0);
    chk("t1_accept_nostart", bus.o_memop_sync_start, 1'b0);
    tick(); idle_in(); settle();
    chk("t1_start", bus.o_memop_sync_start, 1'b1);
    chk("t1_start_id", bus.o_sync_start_id, 1'b0);
    chk("t1_stall_2slot", bus.o_ovi_stall, 1'b0);
    chk("t1_stall_1slot", bus1.o_ovi_stall, 1'b1);
    tick(); bus.i_memop_sync_end = 1'b1; bus.i_sync_end_id = 1'b0; bus.i_lq_empty = 1'b0; settle();
    chk("t1_single_start", bus.o_memop_sync_start, 1'b0);
    tick(); idle_in(); bus.i_lq_empty = 1'b0; settle();
    chk("t1_wait_lq", bus.o_completed_valid, 1'b0);
    chk("t1_wait_stall_1slot", bus1.o_ovi_stall, 1'b1);
    tick(); bus.i_lq_empty = 1'b1; settle();
    chk("t1_complete", {bus.o_completed_valid, bus.o_completed_id}, 2'b10);
    chk("t1_complete_1slot", {bus1.o_completed_valid, bus1.o_completed_id}, 2'b10);
    tick(); settle();
    chk("t1_after", {bus.o_completed_valid, bus.o_ovi_stall, bus.o_err}, 3'b000);
    chk("t1_after_1slot", {bus1.o_completed_valid, bus1.o_ovi_stall, bus1.o_err}, 3'b000);

    // Three-uop store with a load request outstanding, then a second memop.
    do_reset();
    bus.i_mem_req = 1'b1;
    uop(1'b1, 1'b0); settle();
    chk("t2_u0_stall", bus.o_ovi_stall, 1'b0);
    tick(); settle();
    chk("t2_u1_stall_start", {bus.o_ovi_stall, bus.o_memop_sync_start}, 2'b00);
    tick(); bus.i_last_uop = 1'b1; settle();
    chk("t2_u2_stall_start", {bus.o_ovi_stall, bus.o_memop_sync_start}, 2'b00);
    tick(); uop(1'b0, 1'b1); settle();
    chk("t2_store_start", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b10);
    chk("t2_alloc_stall", bus.o_ovi_stall, 1'b0);
    tick(); no_uop(); settle();
    chk("t2_one_pulse", bus.o_memop_sync_start, 1'b0);
    chk("t2_full_stall", bus.o_ovi_stall, 1'b1);
    tick(); bus.i_mem_req = 1'b0; settle();
    chk("t2_load_start", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b11);

    // Sync-ends arrive out of order; retirement stays in order.
    tick(); bus.i_memop_sync_end = 1'b1; bus.i_sync_end_id = 1'b1; settle();
    chk("t3_end1_nocomplete", bus.o_completed_valid, 1'b0);
    tick(); bus.i_sync_end_id = 1'b0; settle();
    chk("t3_no_early_id1", bus.o_completed_valid, 1'b0);
    tick(); bus.i_memop_sync_end = 1'b0; settle();
    chk("t3_complete_id0", {bus.o_completed_valid, bus.o_completed_id}, 2'b10);
    tick(); settle();
    chk("t3_complete_id1", {bus.o_completed_valid, bus.o_completed_id}, 2'b11);
    tick(); settle();
    chk("t3_drained", {bus.o_completed_valid, bus.o_ovi_stall, bus.o_err}, 3'b000);

    // Fill both slots with the load held back by mem_req, then overflow.
    bus.i_mem_req = 1'b1;
    uop(1'b0, 1'b1);
    tick(); uop(1'b1, 1'b1);
    tick(); uop(1'b0, 1'b1); settle();
    chk("t4_full_stall", bus.o_ovi_stall, 1'b1);
    chk("t4_err_before", bus.o_err, 1'b0);
    tick(); no_uop(); bus.i_mem_req = 1'b0; settle();
    chk("t4_err_set", bus.o_err, 1'b1);
    chk("t4_slot0_intact", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b10);
    chk("t4_stall_kept", bus.o_ovi_stall, 1'b1);
    tick(); settle();
    chk("t4_slot1_intact", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b11);

    // Limit 0 disables the watchdog even with sync-end withheld.
    repeat (20) tick();
    settle();
    chk("t5_limit0_never", bus.o_wdog_expired, 1'b0);

    // Watchdog with limit 5.
    do_reset();
    bus.i_wdog_limit = 12'd5;
    uop(1'b0, 1'b1);
    tick(); no_uop(); settle();
    chk("t5_start", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b10);
    repeat (4) tick();
    settle();
    chk("t5_not_yet", bus.o_wdog_expired, 1'b0);
    tick(); tick(); settle();
    chk("t5_expired", bus.o_wdog_expired, 1'b1);

    // Build slot0 COMMIT and slot1 BUSY, then reset in the middle.
    uop(1'b0, 1'b1);
    tick(); no_uop(); bus.i_memop_sync_end = 1'b1; bus.i_sync_end_id = 1'b0; bus.i_lq_empty = 1'b0; settle();
    chk("t6_start_id1", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b11);
    tick(); bus.i_memop_sync_end = 1'b0; settle();
    chk("t6_held", {bus.o_completed_valid, bus.o_ovi_stall, bus.o_wdog_expired}, 3'b011);
    rst = 1'b1;
    tick(); rst = 1'b0; idle_in(); settle();
    chk("t6_reset_outputs", outs2(), 32'd0);
    uop(1'b0, 1'b1);
    tick(); no_uop(); bus.i_memop_sync_end = 1'b1; bus.i_sync_end_id = 1'b0; settle();
    chk("t6_new_slot0", {bus.o_memop_sync_start, bus.o_sync_start_id}, 2'b10);

    // A sync-end in the same cycle as its own start is dropped.
    tick(); bus.i_memop_sync_end = 1'b0; settle();
    chk("t7_early_end_err", bus.o_err, 1'b1);
    chk("t7_no_repeat_start", bus.o_memop_sync_start, 1'b0);
    tick(); settle();
    chk("t7_end_dropped", bus.o_completed_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_memop_tracker.md
Name: tt_memop_tracker

Overview:
- Parametrised successor of the single-memop OVI FSM. Tracks up to NUM_SLOTS vector memops in flight instead of one.
- Allocates one slot per memop at its first accepted uop.
- Issues one sync-start per memop and retires memops in program order.
- Sits between VPU ID/EX and the OVI memop sync interface. Drives o_ovi_stall to ocelot; adds sync IDs, a watchdog and error reporting.

Parameters:
NUM_SLOTS, 2, max memops tracked concurrently (>=1; power of two)
SLOT_W, $clog2(NUM_SLOTS) min 1, slot-id width (derived, not overridden)
WDOG_W, 12, width of sync-end watchdog counter and limit

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_load  in  1  current ID/EX uop is a vector load
i_store  in  1  current ID/EX uop is a vector store
i_id_ex_rts  in  1  ID has uop ready to send
i_ex_rtr  in  1  EX ready to receive
i_last_uop  in  1  current uop is last of its memop
i_lq_empty  in  1  load queue drained
i_mem_req  in  1  ocelot load memory request active
i_memop_sync_end  in  1  sync-end pulse
i_sync_end_id  in  SLOT_W  slot id for sync-end
i_wdog_limit  in  WDOG_W  watchdog cycles; 0 disables
o_memop_sync_start  out  1  sync-start pulse
o_sync_start_id  out  SLOT_W  slot id for sync-start
o_completed_valid  out  1  memop retired
o_completed_id  out  SLOT_W  retired slot id
o_ovi_stall  out  1  no capacity for a new memop
o_wdog_expired  out  1  sticky watchdog flag
o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all slots IDLE; alloc/head/sync pointers 0; watchdog 0; every output 0. Reset mid-operation discards all slots and emits no completions.
- Slot state: IDLE/PREPARE/BUSY/COMMIT, plus is_store bit and sync_sent bit.
- Accept = i_id_ex_rts && i_ex_rtr && (i_load || i_store).
- Accept while a PREPARE slot exists: that slot stays PREPARE. If i_last_uop, it moves to BUSY next cycle.
- Accept with no PREPARE slot and tail slot IDLE: allocate tail and latch is_store = i_store. Slot enters PREPARE, or BUSY if i_last_uop. Tail increments modulo NUM_SLOTS.
- Accept with no PREPARE slot and tail not IDLE: ignored; o_err sets.
- o_ovi_stall = all slots non-IDLE && no slot in PREPARE. Combinational from registered state. NUM_SLOTS=1 reproduces the single-memop stall behaviour.
- Sync-start: candidate is the slot at the sync pointer. It fires when candidate is BUSY && !sync_sent && (is_store || !i_mem_req).
  - Pulse o_memop_sync_start with o_sync_start_id = pointer, same cycle.
  - sync_sent sets; pointer advances. At most one start per cycle; starts are in allocation order.
  - sync_sent is set for stores as well as loads, so no repeated pulse while i_mem_req is high.
- Sync-end: accepted when slot i_sync_end_id is BUSY with registered sync_sent=1. Slot moves to COMMIT next cycle.
  - Any other sync-end (wrong state, or same cycle as its own start) is dropped; o_err sets.
- Commit: head slot in COMMIT && i_lq_empty gives o_completed_valid=1 and o_completed_id=head, same cycle. Slot IDLE next cycle; head increments.
  - Younger COMMIT slots wait for head (in-order retire).
- Simultaneous events: allocation, sync-start, sync-end and retire may all occur in one cycle on different slots. A slot freed this cycle is allocatable next cycle, not same cycle.
- Watchdog: counts while the head slot is BUSY with sync_sent=1; clears on head change or on leaving BUSY.
  - When count == i_wdog_limit (limit != 0), o_wdog_expired sets sticky. Normal operation continues.
- Sticky flags clear only on reset.

Decomposition:
- Package tt_memop_pkg:
  - memop_state_t enum (IDLE=2'b00, PREPARE=2'b01, BUSY=2'b10, COMMIT=2'b11)
  - memop_slot_t struct {state, is_store, sync_sent}
- Sub-module tt_memop_slot: per-slot next-state logic, instantiated NUM_SLOTS times.
- Pointers, arbitration and watchdog live in the top module.

Test Plan:
- Single-uop load, i_mem_req=0: accept with last_uop=1 → sync_start id0 next cycle. Sync_end id0 → completed_valid id0 once lq_empty=1. Stall high from cycle after accept until completion.
- 3-uop store with NUM_SLOTS=2, i_mem_req=1: stall stays 0 through PREPARE. Start fires despite mem_req, exactly one pulse. Second memop allocates slot1 and stall rises.
- Out-of-order sync_end: id1 then id0 → completions id0 then id1 on consecutive cycles; no early completion of id1.
- Full tracker: both slots BUSY, force an accept → ignored, o_err=1, slot states unchanged.
- Watchdog: i_wdog_limit=5, withhold sync_end → o_wdog_expired=1 at 5th cycle after start. With limit=0 it never sets.
- Reset asserted while slot0 COMMIT and slot1 BUSY → next cycle all outputs 0, stall 0. New memop allocates slot0.
